traffic_intersection_ctrl: RTL and testbench
============================================

// Module: traffic_intersection_ctrl
// PURPOSE
// Parametrised N-approach traffic light controller. Successor to the single-signal traffic light block.
// Cycles green -> yellow -> all-red around N_APPROACH approaches in index order, with programmable phase lengths.
// Adds per-approach pedestrian WALK service, a pause via enable, and a flashing-red fail-safe mode.
// Sits at the user-project top. Driven directly by the system clock; outputs go to pad/LED drivers.
// PARAMETERS
// N_APPROACH    2   number of approaches/channels (2..8)
// GREEN_TICKS   8   cycles each approach is green (>=1)
// YELLOW_TICKS  3   cycles of yellow after green (>=1)
// ALLRED_TICKS  2   all-red clearance cycles before next green (>=1)
// WALK_TICKS    4   cycles walk[i] is held at start of approach i green (1..GREEN_TICKS)
// FLASH_HALF    2   half-period, in cycles, of flashing red in flash mode (>=1)
// PORTS
// clk      in   1           system clock, rising edge
// reset    in   1           asynchronous, active-low reset (0 = reset)
// enable   in   1           1 = run; 0 = freeze timer, state and outputs
// flash    in   1           1 = fail-safe flashing red; has priority over enable
// ped_req  in   N_APPROACH  pedestrian request pulse/level per approach, sampled every cycle
// red      out  N_APPROACH  red lamp per approach
// yellow   out  N_APPROACH  yellow lamp per approach
// green    out  N_APPROACH  green lamp per approach
// walk     out  N_APPROACH  pedestrian WALK lamp per approach
// phase    out  $clog2(N_APPROACH)  index of current/last-served approach
// BEHAVIOUR
// - All outputs are registered. Internal timer width is $clog2 of the max tick parameter, plus 1.
// - Reset (reset=0, async): state=ALLRED, cur=N_APPROACH-1, timer=ALLRED_TICKS-1.
//   Outputs: red=all 1s, yellow=0, green=0, walk=0, phase=N_APPROACH-1, ped latches=0.
// - States: ALLRED, GREEN, YELLOW, FLASH. The timer counts down once per enabled cycle.
//   A state lasts exactly its *_TICKS enabled cycles.
// - ALLRED, timer==0: cur <= (cur==N_APPROACH-1) ? 0 : cur+1 (wrap-around); enter GREEN with timer=GREEN_TICKS-1.
// - GREEN, timer==0 -> YELLOW, timer=YELLOW_TICKS-1.
// - YELLOW, timer==0 -> ALLRED, timer=ALLRED_TICKS-1.
// - Lamps: green[cur]=1 in GREEN; yellow[cur]=1 in YELLOW.
//   red[i]=1 for every i not lit green/yellow. Exactly one lamp per approach is lit outside FLASH.
// - Pedestrian requests: ped_req[i]=1 sets latch[i].
//   On entering GREEN for approach i with latch[i]=1: walk[i]=1 for the first WALK_TICKS green cycles, and latch[i] clears.
//   A request arriving during approach i's own GREEN or YELLOW stays latched and is served at its next green.
//   The phase sequence never changes because of a request.
// - enable=0: timer, state, cur and all outputs hold. ped_req is still latched.
//   On enable=1 the sequence resumes with the remaining count.
// - flash=1, sampled at an edge: the next state is FLASH, regardless of enable or current state.
//   In FLASH: green=0, yellow=0, walk=0. red toggles all-1s/all-0s every FLASH_HALF cycles, starting all-1s.
//   ped latches hold.
// - flash falls to 0: enter ALLRED, timer=ALLRED_TICKS-1, red=all 1s. cur is unchanged, so the next green is cur+1.
// - Reset mid-operation: returns to the reset state immediately and asynchronously. Pending requests are discarded.
// - phase reflects cur at all times.
// TESTING (N_APPROACH=2, GREEN=8, YELLOW=3, ALLRED=2, WALK=4, FLASH_HALF=2; cycle 0 = first edge after reset=1)
// 1 Reset/sequence: enable=1.
//   Expect red=11 through cycles 0-1; green=01 for cycles 2-9; yellow=01 for cycles 10-12.
//   Then red=11 for 13-14, green=10 for 15-22, and green=01 again at 28.
// 2 Ped: pulse ped_req=10 at cycle 5.
//   Expect walk=10 for cycles 15-18, walk=00 at 19, and no change to lamp timing.
// 3 Pause: enable=0 during cycles 4-9.
//   Expect green=01 held throughout; yellow starts at cycle 16 instead of 10.
// 4 Flash: flash=1 at cycle 6 for 10 cycles.
//   Expect green=yellow=0 and red alternating 11,11,00,00,...
//   After flash drops: 2 cycles red=11, then green=10.
// 5 Async reset at cycle 20 (mid-green approach 1).
//   Expect red=11, green=0, walk=0 and phase=1 without waiting for a clock edge; the sequence restarts as in test 1.
// 6 Wrap/simultaneous: ped_req=11 held, with flash pulsed one cycle during YELLOW.
//   Expect FLASH entry; both walks are served on their next greens; no two approaches are ever green together.

Source files
------------

// File: rtl/traffic_intersection_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : traffic_intersection_ctrl                                  |
// | Description : N-approach green/yellow/all-red sequencer with pedestrian  |
// |               WALK service, enable pause and flashing-red fail-safe.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module traffic_intersection_ctrl #(
   parameter int N_APPROACH   = 2,
   parameter int GREEN_TICKS  = 8,
   parameter int YELLOW_TICKS = 3,
   parameter int ALLRED_TICKS = 2,
   parameter int WALK_TICKS   = 4,
   parameter int FLASH_HALF   = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          flash,
   input  logic [N_APPROACH-1:0]         ped_req,
   output logic [N_APPROACH-1:0]         red,
   output logic [N_APPROACH-1:0]         yellow,
   output logic [N_APPROACH-1:0]         green,
   output logic [N_APPROACH-1:0]         walk,
   output logic [$clog2(N_APPROACH)-1:0] phase
);

   localparam int c_PW       = $clog2(N_APPROACH);
   localparam int c_MAX_GY   = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
   localparam int c_MAX_AF   = (ALLRED_TICKS > FLASH_HALF) ? ALLRED_TICKS : FLASH_HALF;
   localparam int c_MAX_TICK = (c_MAX_GY > c_MAX_AF) ? c_MAX_GY : c_MAX_AF;
   localparam int c_TW       = $clog2(c_MAX_TICK) + 1;

   localparam logic [c_TW-1:0]       c_GREEN_LD  = c_TW'(GREEN_TICKS - 1);
   localparam logic [c_TW-1:0]       c_YELLOW_LD = c_TW'(YELLOW_TICKS - 1);
   localparam logic [c_TW-1:0]       c_ALLRED_LD = c_TW'(ALLRED_TICKS - 1);
   localparam logic [c_TW-1:0]       c_FLASH_LD  = c_TW'(FLASH_HALF - 1);
   localparam logic [c_TW-1:0]       c_WALK_END  = c_TW'(GREEN_TICKS - WALK_TICKS);
   localparam logic [c_PW-1:0]       c_LAST      = c_PW'(N_APPROACH - 1);
   localparam logic [N_APPROACH-1:0] c_ONE       = N_APPROACH'(1);

   typedef enum logic [1:0] {
      S_ALLRED = 2'd0,
      S_GREEN  = 2'd1,
      S_YELLOW = 2'd2,
      S_FLASH  = 2'd3
   } state_t;

   state_t                r_state,  w_state_n;
   logic [c_PW-1:0]       r_cur,    w_cur_n,   w_cur_inc;
   logic [c_TW-1:0]       r_timer,  w_timer_n, w_timer_dec;
   logic [N_APPROACH-1:0] r_latch,  w_latch_n;
   logic [N_APPROACH-1:0] r_red,    w_red_n,   w_flash_red;
   logic [N_APPROACH-1:0] r_yellow, w_yellow_n;
   logic [N_APPROACH-1:0] r_green,  w_green_n;
   logic [N_APPROACH-1:0] r_walk,   w_walk_n;
   logic [N_APPROACH-1:0] w_inc_oh, w_cur_oh;

   assign w_cur_inc   = (r_cur == c_LAST) ? '0 : r_cur + 1'b1;
   assign w_inc_oh    = c_ONE << w_cur_inc;
   assign w_timer_dec = r_timer - 1'b1;

   // Next-state: flash overrides everything, otherwise advance only when enabled.
   always_comb begin
      w_state_n   = r_state;
      w_cur_n     = r_cur;
      w_timer_n   = r_timer;
      w_walk_n    = r_walk;
      w_flash_red = r_red;
      w_latch_n   = r_latch | ped_req;
      if (flash) begin
         w_state_n = S_FLASH;
         w_walk_n  = '0;
         if (r_state != S_FLASH) begin
            w_timer_n   = c_FLASH_LD;
            w_flash_red = '1;
         end else if (r_timer == '0) begin
            w_timer_n   = c_FLASH_LD;
            w_flash_red = ~r_red;
         end else begin
            w_timer_n = w_timer_dec;
         end
      end else if (r_state == S_FLASH) begin
         w_state_n = S_ALLRED;
         w_timer_n = c_ALLRED_LD;
         w_walk_n  = '0;
      end else if (enable) begin
         if (r_timer != '0) begin
            w_timer_n = w_timer_dec;
            if (r_state == S_GREEN && w_timer_dec < c_WALK_END)
               w_walk_n = '0;
         end else begin
            case (r_state)
               S_ALLRED: begin
                  w_state_n = S_GREEN;
                  w_cur_n   = w_cur_inc;
                  w_timer_n = c_GREEN_LD;
                  // A request landing on this same edge survives for the next green.
                  w_walk_n  = w_inc_oh & r_latch;
                  w_latch_n = (r_latch & ~w_inc_oh) | ped_req;
               end
               S_GREEN: begin
                  w_state_n = S_YELLOW;
                  w_timer_n = c_YELLOW_LD;
                  w_walk_n  = '0;
               end
               default: begin
                  w_state_n = S_ALLRED;
                  w_timer_n = c_ALLRED_LD;
                  w_walk_n  = '0;
               end
            endcase
         end
      end
   end

   always_comb begin
      w_cur_oh   = c_ONE << w_cur_n;
      w_green_n  = (w_state_n == S_GREEN)  ? w_cur_oh : '0;
      w_yellow_n = (w_state_n == S_YELLOW) ? w_cur_oh : '0;
      w_red_n    = (w_state_n == S_FLASH)  ? w_flash_red : ~(w_green_n | w_yellow_n);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_ALLRED;
         r_cur    <= c_LAST;
         r_timer  <= c_ALLRED_LD;
         r_latch  <= '0;
         r_red    <= '1;
         r_yellow <= '0;
         r_green  <= '0;
         r_walk   <= '0;
      end else begin
         r_state  <= w_state_n;
         r_cur    <= w_cur_n;
         r_timer  <= w_timer_n;
         r_latch  <= w_latch_n;
         r_red    <= w_red_n;
         r_yellow <= w_yellow_n;
         r_green  <= w_green_n;
         r_walk   <= w_walk_n;
      end
   end

   assign red    = r_red;
   assign yellow = r_yellow;
   assign green  = r_green;
   assign walk   = r_walk;
   assign phase  = r_cur;

endmodule
`default_nettype wire

// File: tb/tb_traffic_intersection_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_traffic_intersection_ctrl                               |
// | Description : Directed and randomized bench for traffic_intersection_ctrl|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_traffic_intersection_ctrl;

   localparam int N  = 2;
   localparam int G  = 8;
   localparam int Y  = 3;
   localparam int A  = 2;
   localparam int W  = 4;
   localparam int FH = 2;
   localparam int P  = A + G + Y;

   logic         clk     = 1'b0;
   logic         reset   = 1'b1;
   logic         enable  = 1'b0;
   logic         flash   = 1'b0;
   logic [N-1:0] ped_req = '0;
   logic [N-1:0] red, yellow, green, walk;
   logic [0:0]   phase;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   traffic_intersection_ctrl #(
      .N_APPROACH(N), .GREEN_TICKS(G), .YELLOW_TICKS(Y),
      .ALLRED_TICKS(A), .WALK_TICKS(W), .FLASH_HALF(FH)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .flash(flash),
      .ped_req(ped_req), .red(red), .yellow(yellow), .green(green),
      .walk(walk), .phase(phase)
   );

   // Reference: a slot is [all-red A][green G][yellow Y] serving m_app; m_pos is
   // the number of enabled edges into the slot.
   int           m_app, m_pos, m_fcnt, m_fcur;
   bit           m_flash, m_served;
   logic [N-1:0] m_latch;

   function automatic int cur_now();
      if (m_flash) return m_fcur;
      return (m_pos < A) ? (m_app + N - 1) % N : m_app;
   endfunction

   function automatic logic [N-1:0] onehot(int i);
      logic [N-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [N-1:0] exp_green();
      return (!m_flash && m_pos >= A && m_pos < A + G) ? onehot(m_app) : '0;
   endfunction

   function automatic logic [N-1:0] exp_yellow();
      return (!m_flash && m_pos >= A + G) ? onehot(m_app) : '0;
   endfunction

   function automatic logic [N-1:0] exp_red();
      if (m_flash) return (((m_fcnt / FH) % 2) == 0) ? '1 : '0;
      return ~(exp_green() | exp_yellow());
   endfunction

   function automatic logic [N-1:0] exp_walk();
      return (!m_flash && m_served && m_pos >= A && m_pos < A + W) ? onehot(m_app) : '0;
   endfunction

   task automatic model_reset();
      m_app = 0; m_pos = 0; m_fcnt = 0; m_fcur = N - 1;
      m_flash = 1'b0; m_served = 1'b0; m_latch = '0;
   endtask

   task automatic model_edge();
      logic [N-1:0] req;
      req = ped_req;
      if (flash) begin
         if (!m_flash) begin
            m_fcur  = cur_now();
            m_flash = 1'b1;
            m_fcnt  = 0;
         end else begin
            m_fcnt++;
         end
      end else if (m_flash) begin
         m_flash  = 1'b0;
         m_app    = (m_fcur + 1) % N;
         m_pos    = 0;
         m_served = 1'b0;
      end else if (enable) begin
         m_pos++;
         if (m_pos == P) begin
            m_pos = 0;
            m_app = (m_app + 1) % N;
         end
         if (m_pos == A) begin
            m_served         = m_latch[m_app];
            m_latch[m_app]   = 1'b0;
         end
      end
      m_latch = m_latch | req;
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      check("red",    red,    exp_red());
      check("yellow", yellow, exp_yellow());
      check("green",  green,  exp_green());
      check("walk",   walk,   exp_walk());
      check("phase",  phase,  cur_now());
      check("one_green", ($countones(green) <= 1), 1);
   endtask

   // One active edge, then compare 1 time unit later.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      model_reset();
      compare_all();
      check("rst_red",   red,   2'b11);
      check("rst_phase", phase, 1);
      reset = 1'b1;
   endtask

   // Called just after an active edge; reset drops between edges.
   task automatic async_reset();
      #3 reset = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #2 reset = 1'b0;
      #1 model_reset();

      // Basic sequence
      enable = 1'b1;
      do_reset();
      for (int c = 0; c < 30; c++) begin
         tick();
         if (c + 1 == 1)  check("t1_red_c1",    red,    2'b11);
         if (c + 1 == 2)  check("t1_green_c2",  green,  2'b01);
         if (c + 1 == 9)  check("t1_green_c9",  green,  2'b01);
         if (c + 1 == 10) check("t1_yel_c10",   yellow, 2'b01);
         if (c + 1 == 14) check("t1_red_c14",   red,    2'b11);
         if (c + 1 == 15) check("t1_green_c15", green,  2'b10);
         if (c + 1 == 28) check("t1_green_c28", green,  2'b01);
      end

      // Pedestrian pulse on approach 1
      do_reset();
      for (int c = 0; c < 30; c++) begin
         ped_req = (c == 5) ? 2'b10 : 2'b00;
         tick();
         if (c + 1 >= 15 && c + 1 <= 18) check("t2_walk_on", walk, 2'b10);
         if (c + 1 == 19) check("t2_walk_off", walk, 2'b00);
         if (c + 1 == 22) check("t2_green_c22", green, 2'b10);
      end
      ped_req = '0;

      // Pause
      do_reset();
      for (int c = 0; c < 20; c++) begin
         enable = !(c >= 4 && c <= 9);
         tick();
         if (c + 1 == 15) check("t3_green_c15", green,  2'b01);
         if (c + 1 == 16) check("t3_yel_c16",   yellow, 2'b01);
      end
      enable = 1'b1;

      // Flash
      do_reset();
      for (int c = 0; c < 30; c++) begin
         flash = (c >= 6 && c < 16);
         tick();
         if (c + 1 == 9)  check("t4_red_c9",    red,   2'b00);
         if (c + 1 == 11) check("t4_red_c11",   red,   2'b11);
         if (c + 1 == 18) check("t4_red_c18",   red,   2'b11);
         if (c + 1 == 19) check("t4_green_c19", green, 2'b10);
      end
      flash = 1'b0;

      // Async reset mid-green of approach 1
      do_reset();
      for (int c = 0; c < 20; c++) tick();
      #3 reset = 1'b0;
      #1;
      check("t5_red",   red,   2'b11);
      check("t5_green", green, 2'b00);
      check("t5_walk",  walk,  2'b00);
      check("t5_phase", phase, 1);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (c + 1 == 2) check("t5_green_c2", green, 2'b01);
      end

      // Held requests on both approaches, flash pulse during yellow
      do_reset();
      ped_req = 2'b11;
      for (int c = 0; c < 60; c++) begin
         flash = (c == 11);
         tick();
      end
      ped_req = '0;
      flash   = 1'b0;

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         enable = ($urandom_range(0, 7) != 0);
         if (flash) flash = ($urandom_range(0, 5) != 0);
         else       flash = ($urandom_range(0, 60) == 0);
         ped_req = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
         if ($urandom_range(0, 499) == 0) async_reset();
         else                             tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
